// File: rtl/coin_validator.sv
// Coin validator: turns the raw coin-sensor line into one-hot denomination
// strobes. The denomination comes from the measured pulse width. The block
// rejects pulses that fall outside every window, overlap inhibit, or saturate
// the width counter.
module coin_validator #(
    parameter int CNT_W         = 12,
    parameter int NICKEL_MIN    = 10,
    parameter int NICKEL_MAX    = 19,
    parameter int DIME_MIN      = 20,
    parameter int DIME_MAX      = 39,
    parameter int QUARTER_MIN   = 40,
    parameter int QUARTER_MAX   = 79,
    parameter int DOLLAR_MIN    = 80,
    parameter int DOLLAR_MAX    = 159,
    parameter int STROBE_CYCLES = 8,
    parameter int GAP_CYCLES    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic coin_sense,
    input  logic inhibit,
    output logic nickel_out,
    output logic dime_out,
    output logic quarter_out,
    output logic dollar_out,
    output logic reject,
    output logic busy,
    output logic error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MEASURE  = 3'd1,
        CLASSIFY = 3'd2,
        STROBE   = 3'd3,
        REJECT   = 3'd4,
        GAP      = 3'd5
    } state_t;

    localparam int HOLD_W = $clog2(STROBE_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STROBE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    // Inclusive width-window test.
    function automatic logic in_window(input logic [CNT_W-1:0] w, input int lo, input int hi);
        return (w >= CNT_W'(lo)) && (w <= CNT_W'(hi));
    endfunction

    logic              sync_a;
    logic              s;
    logic              s_d;
    logic              rise;
    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              inh_latch;
    logic              inh_latch_next;
    logic              inh_any;
    logic [3:0]        sel;
    logic [3:0]        sel_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;
    logic [GAP_W-1:0]  gap_cnt;
    logic [GAP_W-1:0]  gap_cnt_next;
    logic              strobe_on;

    assign rise = s & ~s_d;

    // Next-state, counter and latch logic for the validator FSM.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        inh_latch_next = inh_latch;
        sel_next       = sel;
        hold_cnt_next  = hold_cnt;
        gap_cnt_next   = gap_cnt;
        inh_any        = inh_latch | inhibit;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next     = MEASURE;
                    cnt_next       = CNT_W'(1);
                    inh_latch_next = inhibit;
                end else begin
                    inh_latch_next = 1'b0;
                end
            end
            MEASURE: begin
                if (s) begin
                    inh_latch_next = inh_any;
                    if (cnt != CNT_MAX) begin
                        cnt_next = cnt + CNT_W'(1);
                    end else begin
                        cnt_next = cnt;
                    end
                end else begin
                    state_next = CLASSIFY;
                end
            end
            CLASSIFY: begin
                inh_latch_next = inh_any;
                hold_cnt_next  = '0;
                sel_next       = 4'b0000;
                // Saturation and inhibit win over any window match.
                if (inh_any || (cnt == CNT_MAX)) begin
                    state_next = REJECT;
                end else if (in_window(cnt, NICKEL_MIN, NICKEL_MAX)) begin
                    state_next = STROBE;
                    sel_next   = 4'b0001;
                end else if (in_window(cnt, DIME_MIN, DIME_MAX)) begin
                    state_next = STROBE;
                    sel_next   = 4'b0010;
                end else if (in_window(cnt, QUARTER_MIN, QUARTER_MAX)) begin
                    state_next = STROBE;
                    sel_next   = 4'b0100;
                end else if (in_window(cnt, DOLLAR_MIN, DOLLAR_MAX)) begin
                    state_next = STROBE;
                    sel_next   = 4'b1000;
                end else begin
                    state_next = REJECT;
                end
            end
            STROBE, REJECT: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next   = GAP;
                    gap_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            GAP: begin
                // Any high sample (bounce or an early coin) restarts the quiet period.
                if (s) begin
                    gap_cnt_next = '0;
                end else if (gap_cnt == GAP_LAST) begin
                    state_next   = IDLE;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        strobe_on = (state_next == STROBE);
    end

    // Input synchronizer, FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a      <= 1'b0;
            s           <= 1'b0;
            s_d         <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            inh_latch   <= 1'b0;
            sel         <= 4'b0000;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            nickel_out  <= 1'b0;
            dime_out    <= 1'b0;
            quarter_out <= 1'b0;
            dollar_out  <= 1'b0;
            reject      <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
        end else begin
            sync_a      <= coin_sense;
            s           <= sync_a;
            s_d         <= s;
            state       <= state_next;
            cnt         <= cnt_next;
            inh_latch   <= inh_latch_next;
            sel         <= sel_next;
            hold_cnt    <= hold_cnt_next;
            gap_cnt     <= gap_cnt_next;
            nickel_out  <= strobe_on & sel_next[0];
            dime_out    <= strobe_on & sel_next[1];
            quarter_out <= strobe_on & sel_next[2];
            dollar_out  <= strobe_on & sel_next[3];
            reject      <= (state_next == REJECT);
            busy        <= (state_next != IDLE);
            error       <= ((state_next == MEASURE) || (state_next == CLASSIFY)) &&
                           (cnt_next == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_coin_validator.sv
// Directed bench for coin_validator: pulses of known width, expected strobe
// timing computed by hand relative to the cycle the raw line was dropped.
module tb_coin_validator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic coin_sense = 1'b0;
    logic inhibit = 1'b0;
    logic nickel_out, dime_out, quarter_out, dollar_out, reject, busy, error;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;

    // Activity monitor: index 0 nickel, 1 dime, 2 quarter, 3 dollar, 4 reject.
    int hi_cnt [5];
    int hi_first [5];
    int hi_last [5];
    int multi_hot = 0;
    int busy_last = -1;
    int err_first = -1;
    int err_last = -1;
    logic [4:0] outs;

    assign outs = {reject, dollar_out, quarter_out, dime_out, nickel_out};

    coin_validator dut (
        .clk        (clk),
        .rst        (rst),
        .coin_sense (coin_sense),
        .inhibit    (inhibit),
        .nickel_out (nickel_out),
        .dime_out   (dime_out),
        .quarter_out(quarter_out),
        .dollar_out (dollar_out),
        .reject     (reject),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Cycle index, valid from #1 after each rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Record output activity on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (outs[k] === 1'b1) begin
                if (hi_first[k] < 0) hi_first[k] = cyc;
                hi_last[k] = cyc;
                hi_cnt[k]  = hi_cnt[k] + 1;
            end
        end
        if ($countones(outs) > 1) multi_hot = multi_hot + 1;
        if (busy === 1'b1) busy_last = cyc;
        if (error === 1'b1) begin
            if (err_first < 0) err_first = cyc;
            err_last = cyc;
        end
    end

    task automatic clear_mon();
        for (int k = 0; k < 5; k++) begin
            hi_cnt[k]   = 0;
            hi_first[k] = -1;
            hi_last[k]  = -1;
        end
        multi_hot = 0;
        busy_last = -1;
        err_first = -1;
        err_last  = -1;
    endtask

    // Raw pin high for n cycles; inhibit pulses for one cycle at index inh_at.
    task automatic drive_pulse(input int n, input int inh_at);
        @(posedge clk); #1;
        rise_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            coin_sense = 1'b1;
            inhibit    = (i == inh_at);
            @(posedge clk); #1;
        end
        coin_sense = 1'b0;
        inhibit    = 1'b0;
        fall_cyc   = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({outs, busy, error} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 0000000", {outs, busy, error});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_denominations();
        int widths [4];
        int f;
        widths = '{15, 30, 50, 100};
        for (int v = 0; v < 4; v++) begin
            clear_mon();
            drive_pulse(widths[v], -1);
            f = fall_cyc;
            repeat (40) @(posedge clk);
            #1;
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (hi_cnt[k] !== ((k == v) ? 8 : 0)) begin
                    n_bad++;
                    $display("FAIL denom w=%0d out%0d_cycles: got %0d expected %0d",
                             widths[v], k, hi_cnt[k], (k == v) ? 8 : 0);
                end
            end
            n_cmp++;
            if (hi_first[v] !== f + 4 || hi_last[v] !== f + 11) begin
                n_bad++;
                $display("FAIL denom w=%0d timing: got %0d..%0d expected %0d..%0d",
                         widths[v], hi_first[v], hi_last[v], f + 4, f + 11);
            end
            n_cmp++;
            if (busy_last !== f + 27) begin
                n_bad++;
                $display("FAIL denom w=%0d busy_last: got %0d expected %0d", widths[v], busy_last, f + 27);
            end
            n_cmp++;
            if (multi_hot !== 0) begin
                n_bad++;
                $display("FAIL denom w=%0d onehot: got %0d expected 0", widths[v], multi_hot);
            end
        end
    endtask

    task automatic test_boundaries();
        int widths [3];
        int exp_idx [3];
        int f;
        widths  = '{9, 19, 160};
        exp_idx = '{4, 0, 4};
        for (int v = 0; v < 3; v++) begin
            clear_mon();
            drive_pulse(widths[v], -1);
            f = fall_cyc;
            repeat (40) @(posedge clk);
            #1;
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (hi_cnt[k] !== ((k == exp_idx[v]) ? 8 : 0)) begin
                    n_bad++;
                    $display("FAIL boundary w=%0d out%0d_cycles: got %0d expected %0d",
                             widths[v], k, hi_cnt[k], (k == exp_idx[v]) ? 8 : 0);
                end
            end
            n_cmp++;
            if (hi_first[exp_idx[v]] !== f + 4) begin
                n_bad++;
                $display("FAIL boundary w=%0d first: got %0d expected %0d", widths[v], hi_first[exp_idx[v]], f + 4);
            end
        end
    endtask

    task automatic test_inhibit();
        int f;
        clear_mon();
        drive_pulse(100, 50);
        f = fall_cyc;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (hi_cnt[4] !== 8 || hi_first[4] !== f + 4) begin
            n_bad++;
            $display("FAIL inhibit_reject: got %0d cycles from %0d expected 8 from %0d", hi_cnt[4], hi_first[4], f + 4);
        end
        n_cmp++;
        if (hi_cnt[3] !== 0) begin
            n_bad++;
            $display("FAIL inhibit_dollar: got %0d cycles expected 0", hi_cnt[3]);
        end
    endtask

    task automatic test_glitch_gap();
        int f;
        clear_mon();
        drive_pulse(50, -1);
        f = fall_cyc;
        // Strobe ends at f+11; glitch raised 5 cycles later for 3 cycles.
        repeat (16) @(posedge clk);
        #1;
        coin_sense = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        coin_sense = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (hi_cnt[2] !== 8 || hi_cnt[0] + hi_cnt[1] + hi_cnt[3] + hi_cnt[4] !== 0) begin
            n_bad++;
            $display("FAIL glitch_outputs: got quarter=%0d others=%0d expected 8/0",
                     hi_cnt[2], hi_cnt[0] + hi_cnt[1] + hi_cnt[3] + hi_cnt[4]);
        end
        n_cmp++;
        if (busy_last !== f + 36) begin
            n_bad++;
            $display("FAIL glitch_busy_last: got %0d expected %0d", busy_last, f + 36);
        end
    endtask

    task automatic test_stuck_sensor();
        int f;
        int r;
        clear_mon();
        drive_pulse(5000, -1);
        f = fall_cyc;
        r = rise_cyc;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (err_first !== r + 4097 || err_last !== f + 3) begin
            n_bad++;
            $display("FAIL stuck_error: got %0d..%0d expected %0d..%0d", err_first, err_last, r + 4097, f + 3);
        end
        n_cmp++;
        if (hi_cnt[4] !== 8 || hi_first[4] !== f + 4) begin
            n_bad++;
            $display("FAIL stuck_reject: got %0d cycles from %0d expected 8 from %0d", hi_cnt[4], hi_first[4], f + 4);
        end
        n_cmp++;
        if (error !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_error_clear: got %b expected 0", error);
        end
    endtask

    task automatic test_reset_mid_strobe();
        int f;
        clear_mon();
        drive_pulse(50, -1);
        f = fall_cyc;
        // Quarter strobe occupies f+4..; rst sampled at the end of its 4th cycle.
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({outs, busy, error} !== 7'b0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b expected 0000000", {outs, busy, error});
        end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (hi_cnt[2] !== 4) begin
            n_bad++;
            $display("FAIL midreset_quarter_cycles: got %0d expected 4", hi_cnt[2]);
        end
        clear_mon();
        drive_pulse(15, -1);
        f = fall_cyc;
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if (hi_cnt[0] !== 8 || hi_first[0] !== f + 4 || hi_cnt[4] !== 0) begin
            n_bad++;
            $display("FAIL midreset_nickel: got %0d cycles from %0d reject=%0d expected 8 from %0d reject=0",
                     hi_cnt[0], hi_first[0], hi_cnt[4], f + 4);
        end
    endtask

    // Scenario sequence.
    initial begin
        clear_mon();
        test_reset();
        test_denominations();
        test_boundaries();
        test_inhibit();
        test_glitch_gap();
        test_stuck_sensor();
        test_reset_mid_strobe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
